apb_gpio_arbiter: RTL and testbench
===================================

Name: apb_gpio_arbiter

Overview:
Shares one APB GPIO slave register port between N_MASTERS independent APB requesters, for example two cores or a core plus a debug unit.
- Round-robin arbitration.
- Each granted request is re-issued downstream as exactly one APB SETUP/ACCESS transfer.
- The slave's response is returned to the winning requester only.
- A per-transfer timeout protects against a slave that never raises PREADY.
- The block sits between the interconnect's peripheral ports and the GPIO slave.

Parameters:
APB_ADDR_WIDTH, 12, address width on all ports.
N_MASTERS, 2, number of requesters (legal range 2..8).
TIMEOUT_CYCLES, 64, maximum ACCESS-phase cycles waiting for m_PREADY before aborting (legal range 1..255).

Ports:
HCLK  in  1  clock
HRESET  in  1  reset (synchronous, active-high)
s_PADDR  in  N_MASTERS*APB_ADDR_WIDTH  requester addresses, requester i in slice i
s_PWDATA  in  N_MASTERS*32  requester write data
s_PWRITE  in  N_MASTERS  requester write flags
s_PSEL  in  N_MASTERS  requester selects
s_PENABLE  in  N_MASTERS  requester enables
s_PRDATA  out  32  read data, shared by all requesters, valid only with the granted s_PREADY bit
s_PREADY  out  N_MASTERS  per-requester ready
s_PSLVERR  out  N_MASTERS  per-requester error
m_PADDR  out  APB_ADDR_WIDTH  to slave
m_PWDATA  out  32  to slave
m_PWRITE  out  1  to slave
m_PSEL  out  1  to slave
m_PENABLE  out  1  to slave
m_PRDATA  in  32  from slave
m_PREADY  in  1  from slave
m_PSLVERR  in  1  from slave

Behaviour:
- Reset (HRESET high at a HCLK edge): state IDLE, rr pointer 0, timeout counter 0.
  - All m_* outputs, s_PREADY, s_PSLVERR and s_PRDATA are 0 from the next cycle.
  - Reset mid-transfer drops m_PSEL and m_PENABLE on the following cycle. No response is returned.
- Request: requester i is pending when s_PSEL[i]=1, in either its SETUP or its ACCESS phase.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If any request is pending, select the winner g: the first pending index at or after the rr pointer, wrapping modulo N_MASTERS.
  - Latch s_PADDR, s_PWDATA and s_PWRITE of g. Go to SETUP.
- SETUP: m_PSEL=1, m_PENABLE=0, m_* carry the latched values. Go to ACCESS.
- ACCESS: m_PSEL=1, m_PENABLE=1. The counter increments each cycle.
  - m_PREADY=1: capture m_PRDATA and m_PSLVERR, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with m_PREADY still 0: capture PRDATA=0 and PSLVERR=1, drop m_PSEL, go to RESP.
- RESP:
  - m_PSEL=0. s_PREADY[g]=1 for exactly one cycle, with s_PRDATA and s_PSLVERR[g] taken from the captured values.
  - rr pointer becomes (g+1) mod N_MASTERS. Return to IDLE.
  - Non-granted s_PREADY bits stay 0.
- Latency:
  - Minimum is 4 cycles from s_PSEL sampled to s_PREADY (IDLE, SETUP, ACCESS, RESP) with a zero-wait slave.
  - Each slave wait state adds 1 cycle.
  - There is always at least one IDLE cycle between consecutive downstream transfers.
- Exactly one downstream access per granted request; never speculative or repeated. This is required because reading INTSTATUS on the slave has a side effect (it clears the interrupt).
- Simultaneous requests: resolved by rr order only. A requester that loses waits with PSEL held. Starvation bound is N_MASTERS-1 transfers.
- Granted requester drops s_PSEL before RESP (protocol violation): the downstream transfer still completes and the response is discarded (s_PREADY stays 0). The rr pointer still advances.
- Requester inputs are ignored between latch and RESP. Changes to s_PADDR or s_PWDATA mid-transfer do not reach m_*.
- Widths: the rr pointer is clog2(N_MASTERS) bits, wrapping at N_MASTERS-1 to 0. The timeout counter is 8 bits and is cleared on entry to SETUP.

Decomposition:
- Package apb_gpio_arbiter_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS, RESP);
  - the localparam for pointer width derived from the maximum of 8 masters;
  - the timeout counter width constant.
- Sub-module rr_arbiter (request vector plus pointer in, one-hot grant plus encoded index out) is purely combinational. It is instantiated once and is reusable by other shared peripherals.

Test Plan:
- Single write: requester 0 writes PADDR=0x008, PWDATA=0xA5A5_0001, slave with zero wait states -> m_PSEL/m_PENABLE for 1 SETUP + 1 ACCESS cycle with the same addr/data; s_PREADY[0] high exactly 4 cycles after PSEL is sampled; s_PREADY[1]=0.
- Contention: both requesters assert PSEL in the same cycle (req0 reads 0x004, req1 writes 0x00C=0xFF) after reset -> req0 is served first and req1 second; the pointer then favours req0 on the next tie. Sixteen back-to-back tie rounds alternate grants 0,1,0,1.
- Wait states and read data: slave holds PREADY=0 for 5 ACCESS cycles, then returns PRDATA=0x1234_5678 -> s_PRDATA=0x1234_5678 with s_PREADY[g] on the next cycle; total latency 9 cycles.
- Timeout: slave never asserts PREADY, TIMEOUT_CYCLES=4 -> m_PSEL drops after 4 ACCESS cycles; s_PSLVERR[g]=1 with s_PRDATA=0; the next request is served normally.
- Side-effect safety: req1 reads 0x018 (INTSTATUS) while req0 is pending -> exactly one downstream read of 0x018 is seen (bench counts m_PSEL&m_PENABLE&m_PREADY at that address = 1).
- Reset mid-transfer: HRESET pulsed during ACCESS -> m_PSEL=0, m_PENABLE=0, s_PREADY=0 the next cycle; the pointer returns to 0, so a subsequent tie grants req0.

Source files
------------

// File: rtl/apb_gpio_arbiter_pkg.sv
// Shared types and widths for the APB GPIO requester arbiter.
// Imported by the top-level FSM and the reusable round-robin picker.
package apb_gpio_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } arb_state_e;

  localparam int MAX_MASTERS = 8;
  localparam int PTR_W       = $clog2(MAX_MASTERS);
  localparam int TO_CNT_W    = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr wins,
// wrapping modulo N. Index ports are sized for the largest supported N.
module rr_arbiter
  import apb_gpio_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  logic [N-1:0] rot;
  int           sum;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = 0;
    rot   = N'({req, req} >> ptr);
    // Walk from the highest rotated position down so the lowest one (nearest ptr) sticks.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        valid = 1'b1;
        sum   = int'(ptr) + j;
      end
    end
    if (sum >= N) sum = sum - N;
    idx = PTR_W'(sum);
    if (valid) grant = N'(1) << idx;
  end

endmodule

// File: rtl/apb_gpio_arbiter.sv
// Funnels N APB requesters onto one GPIO slave port: one downstream transfer per
// grant, response routed back to the winner only, with an ACCESS-phase timeout.
module apb_gpio_arbiter
  import apb_gpio_arbiter_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [N_MASTERS*APB_ADDR_WIDTH-1:0] s_PADDR,
  input  logic [N_MASTERS*32-1:0]       s_PWDATA,
  input  logic [N_MASTERS-1:0]          s_PWRITE,
  input  logic [N_MASTERS-1:0]          s_PSEL,
  input  logic [N_MASTERS-1:0]          s_PENABLE,
  output logic [31:0]                   s_PRDATA,
  output logic [N_MASTERS-1:0]          s_PREADY,
  output logic [N_MASTERS-1:0]          s_PSLVERR,
  output logic [APB_ADDR_WIDTH-1:0]     m_PADDR,
  output logic [31:0]                   m_PWDATA,
  output logic                          m_PWRITE,
  output logic                          m_PSEL,
  output logic                          m_PENABLE,
  input  logic [31:0]                   m_PRDATA,
  input  logic                          m_PREADY,
  input  logic                          m_PSLVERR
);

  localparam int RR_W = $clog2(N_MASTERS);

  arb_state_e              state;
  logic [RR_W-1:0]         rr_ptr;
  logic [TO_CNT_W-1:0]     to_cnt;
  logic [TO_CNT_W-1:0]     to_next;
  logic                    timeout_hit;
  logic [N_MASTERS-1:0]    gnt_oh;
  logic [PTR_W-1:0]        gnt_idx;
  logic                    deliver;

  logic [N_MASTERS-1:0]    arb_grant;
  logic [PTR_W-1:0]        arb_idx;
  logic                    arb_valid;

  logic [APB_ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]               sel_wdata;
  logic                      sel_write;

  rr_arbiter #(.N(N_MASTERS)) u_rr_arbiter (
    .req   (s_PSEL),
    .ptr   (PTR_W'(rr_ptr)),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = s_PADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        sel_wdata = s_PWDATA[i*32 +: 32];
        sel_write = s_PWRITE[i];
      end
    end
  end

  assign to_next     = to_cnt + 1'b1;
  assign timeout_hit = !m_PREADY && (to_next == TO_CNT_W'(TIMEOUT_CYCLES));
  // A winner that abandoned its request still gets its transfer, but no response.
  assign deliver     = |(s_PSEL & gnt_oh);

  // NOTE: gnt_oh/gnt_idx are deliberately left out of reset; they are always
  // loaded in IDLE before anything reads them.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      to_cnt    <= '0;
      m_PADDR   <= '0;
      m_PWDATA  <= '0;
      m_PWRITE  <= 1'b0;
      m_PSEL    <= 1'b0;
      m_PENABLE <= 1'b0;
      s_PREADY  <= '0;
      s_PSLVERR <= '0;
      s_PRDATA  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt_oh    <= arb_grant;
            gnt_idx   <= arb_idx;
            m_PADDR   <= sel_addr;
            m_PWDATA  <= sel_wdata;
            m_PWRITE  <= sel_write;
            m_PSEL    <= 1'b1;
            m_PENABLE <= 1'b0;
            to_cnt    <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          m_PENABLE <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          to_cnt <= to_next;
          if (m_PREADY || timeout_hit) begin
            m_PSEL    <= 1'b0;
            m_PENABLE <= 1'b0;
            s_PREADY  <= deliver ? gnt_oh : '0;
            s_PSLVERR <= (deliver && (m_PREADY ? m_PSLVERR : 1'b1)) ? gnt_oh : '0;
            s_PRDATA  <= (deliver && m_PREADY) ? m_PRDATA : '0;
            state     <= RESP;
          end
        end
        RESP: begin
          s_PREADY  <= '0;
          s_PSLVERR <= '0;
          s_PRDATA  <= '0;
          rr_ptr    <= (gnt_idx == PTR_W'(N_MASTERS - 1)) ? '0 : RR_W'(gnt_idx + 1'b1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Scoreboard bench for apb_gpio_arbiter: two requesters, a configurable slave
// model, and per-feature tasks driving traffic through a single sampling loop.
module tb_apb_gpio_arbiter;

  localparam int AW = 12;
  localparam int NM = 2;
  localparam int TO = 6;
  localparam logic [AW-1:0] INTSTATUS = 12'h018;

  logic              HCLK;
  logic              HRESET;
  logic [NM*AW-1:0]  s_PADDR;
  logic [NM*32-1:0]  s_PWDATA;
  logic [NM-1:0]     s_PWRITE;
  logic [NM-1:0]     s_PSEL;
  logic [NM-1:0]     s_PENABLE;
  logic [31:0]       s_PRDATA;
  logic [NM-1:0]     s_PREADY;
  logic [NM-1:0]     s_PSLVERR;
  logic [AW-1:0]     m_PADDR;
  logic [31:0]       m_PWDATA;
  logic              m_PWRITE;
  logic              m_PSEL;
  logic              m_PENABLE;
  logic [31:0]       m_PRDATA;
  logic              m_PREADY;
  logic              m_PSLVERR;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
    int          t0;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          write;
  } xfer_t;

  rsp_t  exp_up[$];
  xfer_t exp_dn[$];
  int    grant_log[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_lat = 0;
  int acc_cycles = 0;
  int setup_cnt = 0;
  int intstat_rd = 0;

  int          slv_wait = 0;
  logic        slv_hang = 1'b0;
  logic        slv_ovr = 1'b0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          acc_cnt = 0;

  apb_gpio_arbiter #(
    .APB_ADDR_WIDTH (AW),
    .N_MASTERS      (NM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .s_PADDR   (s_PADDR),
    .s_PWDATA  (s_PWDATA),
    .s_PWRITE  (s_PWRITE),
    .s_PSEL    (s_PSEL),
    .s_PENABLE (s_PENABLE),
    .s_PRDATA  (s_PRDATA),
    .s_PREADY  (s_PREADY),
    .s_PSLVERR (s_PSLVERR),
    .m_PADDR   (m_PADDR),
    .m_PWDATA  (m_PWDATA),
    .m_PWRITE  (m_PWRITE),
    .m_PSEL    (m_PSEL),
    .m_PENABLE (m_PENABLE),
    .m_PRDATA  (m_PRDATA),
    .m_PREADY  (m_PREADY),
    .m_PSLVERR (m_PSLVERR)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] slv_data(input logic [AW-1:0] a, input logic ovr,
                                           input logic [31:0] val);
    return ovr ? val : {20'hCAFE0, a};
  endfunction

  // Slave model: inserts slv_wait wait states, or never responds when slv_hang is set.
  always @(posedge HCLK) acc_cnt <= (m_PSEL && m_PENABLE && !m_PREADY) ? acc_cnt + 1 : 0;
  assign m_PREADY  = m_PSEL && m_PENABLE && !slv_hang && (acc_cnt >= slv_wait);
  assign m_PRDATA  = m_PREADY ? slv_data(m_PADDR, slv_ovr, slv_rdata) : 32'h0;
  assign m_PSLVERR = m_PREADY && slv_err;

  // One clock of observation: downstream and upstream scoreboards, then requester handshake.
  task automatic step();
    rsp_t        r;
    xfer_t       x;
    logic [NM-1:0] ev;
    int          g;
    @(negedge HCLK);
    cyc++;
    if (!HRESET) begin
      if (m_PSEL && !m_PENABLE) begin
        setup_cnt++;
        if (exp_dn.size() > 0) begin
          n_cmp++;
          if (m_PADDR !== exp_dn[0].addr) begin
            n_bad++;
            $display("FAIL setup_addr: got %h want %h (cycle %0d)", m_PADDR, exp_dn[0].addr, cyc);
          end
        end
      end
      if (m_PSEL && m_PENABLE) acc_cycles++;
      if (m_PSEL && m_PENABLE && m_PREADY) begin
        if (m_PADDR == INTSTATUS && !m_PWRITE) intstat_rd++;
        n_cmp++;
        if (exp_dn.size() == 0) begin
          n_bad++;
          $display("FAIL dn_unexpected: addr %h write %b (cycle %0d)", m_PADDR, m_PWRITE, cyc);
        end else begin
          x = exp_dn.pop_front();
          if (m_PADDR !== x.addr || m_PWDATA !== x.wdata || m_PWRITE !== x.write) begin
            n_bad++;
            $display("FAIL dn_xfer: got %h/%h/%b want %h/%h/%b", m_PADDR, m_PWDATA, m_PWRITE,
                     x.addr, x.wdata, x.write);
          end
        end
      end
      if (s_PREADY !== '0) begin
        n_cmp++;
        if (exp_up.size() == 0) begin
          n_bad++;
          $display("FAIL up_unexpected: s_PREADY %b (cycle %0d)", s_PREADY, cyc);
        end else begin
          r = exp_up.pop_front();
          ev = '0;
          ev[r.idx] = 1'b1;
          g = -1;
          for (int i = 0; i < NM; i++) if (s_PREADY[i]) g = i;
          grant_log.push_back(g);
          last_lat = cyc - r.t0 + 1;
          if (s_PREADY !== ev || s_PRDATA !== r.data || s_PSLVERR !== (r.err ? ev : '0)) begin
            n_bad++;
            $display("FAIL up_rsp: got rdy %b data %h err %b want rdy %b data %h err %b",
                     s_PREADY, s_PRDATA, s_PSLVERR, ev, r.data, r.err ? ev : '0);
          end
        end
      end else if (s_PRDATA !== '0 || s_PSLVERR !== '0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idle_rsp: data %h err %b without ready", s_PRDATA, s_PSLVERR);
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (s_PREADY[i] === 1'b1) begin
        s_PSEL[i]    = 1'b0;
        s_PENABLE[i] = 1'b0;
      end else if (s_PSEL[i]) begin
        s_PENABLE[i] = 1'b1;
      end
    end
  endtask

  task automatic issue(input int i, input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic write, input bit want_rsp, input bit hang);
    rsp_t  r;
    xfer_t x;
    s_PSEL[i]               = 1'b1;
    s_PENABLE[i]            = 1'b0;
    s_PADDR[i*AW +: AW]     = addr;
    s_PWDATA[i*32 +: 32]    = wdata;
    s_PWRITE[i]             = write;
    if (!hang) begin
      x.addr = addr; x.wdata = wdata; x.write = write;
      exp_dn.push_back(x);
    end
    if (want_rsp) begin
      r.idx  = i;
      r.data = hang ? 32'h0 : slv_data(addr, slv_ovr, slv_rdata);
      r.err  = hang ? 1'b1 : slv_err;
      r.t0   = cyc;
      exp_up.push_back(r);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    step();
    while (!(exp_up.size() == 0 && exp_dn.size() == 0 && s_PSEL == '0 && !m_PSEL) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: budget %0d expired, %0d rsp / %0d xfer outstanding",
               budget, exp_up.size(), exp_dn.size());
      exp_up.delete();
      exp_dn.delete();
      s_PSEL    = '0;
      s_PENABLE = '0;
    end
    step();
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    step();
    step();
    HRESET = 1'b0;
    step();
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    step();
    step();
    n_cmp++;
    if ({m_PSEL, m_PENABLE, m_PWRITE} !== 3'b000 || m_PADDR !== '0 || m_PWDATA !== '0) begin
      n_bad++;
      $display("FAIL reset_m: psel %b pen %b wr %b addr %h wdata %h want all 0",
               m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA);
    end
    n_cmp++;
    if (s_PREADY !== '0 || s_PSLVERR !== '0 || s_PRDATA !== '0) begin
      n_bad++;
      $display("FAIL reset_s: rdy %b err %b data %h want all 0", s_PREADY, s_PSLVERR, s_PRDATA);
    end
    HRESET = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    int a0 = acc_cycles;
    int s0 = setup_cnt;
    issue(0, 12'h008, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0);
    wait_idle(20);
    n_cmp++;
    if (last_lat !== 4) begin
      n_bad++;
      $display("FAIL single_latency: got %0d want 4", last_lat);
    end
    n_cmp++;
    if (acc_cycles - a0 !== 1 || setup_cnt - s0 !== 1) begin
      n_bad++;
      $display("FAIL single_phases: setup %0d access %0d want 1/1", setup_cnt - s0, acc_cycles - a0);
    end
  endtask

  task automatic test_contention();
    do_reset();
    grant_log.delete();
    issue(0, 12'h004, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1, 12'h00C, 32'h0000_00FF, 1'b1, 1'b1, 1'b0);
    wait_idle(30);
    for (int r = 0; r < 16; r++) begin
      issue(0, AW'(12'h020 + r), 32'h100 + r, 1'b1, 1'b1, 1'b0);
      issue(1, AW'(12'h040 + r), 32'h200 + r, 1'b0, 1'b1, 1'b0);
      wait_idle(30);
    end
    n_cmp++;
    if (grant_log.size() !== 34) begin
      n_bad++;
      $display("FAIL tie_count: got %0d grants want 34", grant_log.size());
    end else begin
      for (int k = 0; k < 34; k++) begin
        n_cmp++;
        if (grant_log[k] !== k % 2) begin
          n_bad++;
          $display("FAIL tie_order[%0d]: got %0d want %0d", k, grant_log[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_rr_pointer();
    issue(0, 12'h000, 32'h11, 1'b1, 1'b1, 1'b0);
    wait_idle(20);
    grant_log.delete();
    issue(1, 12'h004, 32'h22, 1'b1, 1'b1, 1'b0);
    issue(0, 12'h008, 32'h33, 1'b0, 1'b1, 1'b0);
    wait_idle(30);
    n_cmp++;
    if (grant_log.size() !== 2 || grant_log[0] !== 1 || grant_log[1] !== 0) begin
      n_bad++;
      $display("FAIL rr_after_req0: got %p want '{1, 0}", grant_log);
    end
  endtask

  task automatic test_wait_states();
    int a0 = acc_cycles;
    slv_wait  = 5;
    slv_ovr   = 1'b1;
    slv_rdata = 32'h1234_5678;
    issue(1, 12'h010, 32'h0, 1'b0, 1'b1, 1'b0);
    wait_idle(40);
    n_cmp++;
    if (last_lat !== 9) begin
      n_bad++;
      $display("FAIL wait_latency: got %0d want 9", last_lat);
    end
    n_cmp++;
    if (acc_cycles - a0 !== 6) begin
      n_bad++;
      $display("FAIL wait_access: got %0d access cycles want 6", acc_cycles - a0);
    end
    slv_wait = 0;
    slv_err  = 1'b1;
    issue(0, 12'h01C, 32'h0000_005A, 1'b1, 1'b1, 1'b0);
    wait_idle(20);
    slv_err = 1'b0;
    slv_ovr = 1'b0;
  endtask

  task automatic test_timeout();
    int a0 = acc_cycles;
    slv_hang = 1'b1;
    issue(0, 12'h014, 32'h0, 1'b0, 1'b1, 1'b1);
    wait_idle(40);
    n_cmp++;
    if (acc_cycles - a0 !== TO) begin
      n_bad++;
      $display("FAIL timeout_access: got %0d access cycles want %0d", acc_cycles - a0, TO);
    end
    n_cmp++;
    if (last_lat !== TO + 3) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d want %0d", last_lat, TO + 3);
    end
    slv_hang = 1'b0;
    issue(1, 12'h008, 32'h0000_00FF, 1'b1, 1'b1, 1'b0);
    wait_idle(20);
    n_cmp++;
    if (last_lat !== 4) begin
      n_bad++;
      $display("FAIL after_timeout_latency: got %0d want 4", last_lat);
    end
  endtask

  task automatic test_side_effect();
    int i0 = intstat_rd;
    int s0 = setup_cnt;
    slv_wait = 2;
    issue(0, 12'h000, 32'h1, 1'b1, 1'b1, 1'b0);
    issue(1, INTSTATUS, 32'h0, 1'b0, 1'b1, 1'b0);
    wait_idle(60);
    n_cmp++;
    if (intstat_rd - i0 !== 1) begin
      n_bad++;
      $display("FAIL intstatus_reads: got %0d want 1", intstat_rd - i0);
    end
    n_cmp++;
    if (setup_cnt - s0 !== 2) begin
      n_bad++;
      $display("FAIL side_setups: got %0d want 2", setup_cnt - s0);
    end
    slv_wait = 0;
  endtask

  task automatic test_drop_psel();
    int s0 = setup_cnt;
    issue(0, 12'h01C, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    s_PSEL[0]    = 1'b0;
    s_PENABLE[0] = 1'b0;
    wait_idle(20);
    n_cmp++;
    if (setup_cnt - s0 !== 1) begin
      n_bad++;
      $display("FAIL drop_setups: got %0d want 1", setup_cnt - s0);
    end
    grant_log.delete();
    issue(1, 12'h004, 32'h44, 1'b1, 1'b1, 1'b0);
    issue(0, 12'h008, 32'h55, 1'b1, 1'b1, 1'b0);
    wait_idle(30);
    n_cmp++;
    if (grant_log.size() !== 2 || grant_log[0] !== 1 || grant_log[1] !== 0) begin
      n_bad++;
      $display("FAIL drop_rr: got %p want '{1, 0}", grant_log);
    end
  endtask

  task automatic test_reset_mid();
    slv_hang = 1'b1;
    issue(0, 12'h004, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    n_cmp++;
    if (!(m_PSEL && m_PENABLE)) begin
      n_bad++;
      $display("FAIL mid_in_access: psel %b pen %b want 1/1", m_PSEL, m_PENABLE);
    end
    HRESET = 1'b1;
    step();
    n_cmp++;
    if (m_PSEL !== 1'b0 || m_PENABLE !== 1'b0 || s_PREADY !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: psel %b pen %b rdy %b want 0/0/0", m_PSEL, m_PENABLE, s_PREADY);
    end
    s_PSEL    = '0;
    s_PENABLE = '0;
    HRESET    = 1'b0;
    slv_hang  = 1'b0;
    step();
    grant_log.delete();
    issue(0, 12'h00C, 32'h66, 1'b1, 1'b1, 1'b0);
    issue(1, 12'h010, 32'h77, 1'b0, 1'b1, 1'b0);
    wait_idle(30);
    n_cmp++;
    if (grant_log.size() !== 2 || grant_log[0] !== 0 || grant_log[1] !== 1) begin
      n_bad++;
      $display("FAIL mid_rr: got %p want '{0, 1}", grant_log);
    end
  endtask

  initial begin
    HRESET    = 1'b1;
    s_PADDR   = '0;
    s_PWDATA  = '0;
    s_PWRITE  = '0;
    s_PSEL    = '0;
    s_PENABLE = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_rr_pointer();
    test_wait_states();
    test_timeout();
    test_side_effect();
    test_drop_psel();
    test_reset_mid();
    n_cmp++;
    if (exp_up.size() !== 0 || exp_dn.size() !== 0) begin
      n_bad++;
      $display("FAIL leftover: %0d rsp / %0d xfer never seen", exp_up.size(), exp_dn.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
